// File: rtl/secded_decoder_pipe.sv
// Two-stage SECDED (extended Hamming) decoder with valid/ready flow control
// and saturating single/double error event counters.
module secded_decoder_pipe #(
  parameter  int DATA_W = 16,
  parameter  int CNT_W  = 8,
  localparam int P      = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
  localparam int CW_W   = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  input  logic              correct_en,
  input  logic              cnt_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [P-1:0]      out_syn,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  localparam logic [P-1:0]     SYN_MAX = P'(CW_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Bit b of the syndrome is the parity of every position whose index has bit b set.
  function automatic logic [CW_W-1:0] syn_mask(input int b);
    logic [CW_W-1:0] m;
    m = '0;
    for (int i = 1; i < CW_W; i++) m[i] = ((i >> b) & 1) != 0;
    return m;
  endfunction

  // Codeword position of data bit k: k-th non-power-of-two index above 0.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == k) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic              s1_adv;
  logic              s2_adv;
  logic              out_hs;

  logic [P-1:0]      syn_next;
  logic              par_next;
  logic [DATA_W-1:0] raw_next;

  logic              s1_valid_reg;
  logic [P-1:0]      s1_syn_reg;
  logic              s1_par_reg;
  logic [DATA_W-1:0] s1_data_reg;
  logic              s1_mode_reg;

  logic              syn_zero;
  logic              sec_next;
  logic              ded_next;
  logic              fix_en;
  logic [DATA_W-1:0] corr_next;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_sec_reg;
  logic              out_ded_reg;
  logic [P-1:0]      out_syn_reg;
  logic [CNT_W-1:0]  sec_cnt_reg;
  logic [CNT_W-1:0]  ded_cnt_reg;

  genvar gi;

  generate
    for (gi = 0; gi < P; gi++) begin : g_syn
      localparam logic [CW_W-1:0] MASK = syn_mask(gi);
      assign syn_next[gi] = ^(in_cw & MASK);
    end

    for (gi = 0; gi < DATA_W; gi++) begin : g_data
      localparam int POS = data_pos(gi);
      assign raw_next[gi]  = in_cw[POS];
      assign corr_next[gi] = s1_data_reg[gi] ^ (fix_en && (s1_syn_reg == P'(POS)));
    end
  endgenerate

  assign par_next = ^in_cw;

  // A zero syndrome with odd parity means only the overall parity bit flipped.
  always_comb begin
    syn_zero = (s1_syn_reg == '0);
    sec_next = s1_par_reg && (s1_syn_reg <= SYN_MAX);
    ded_next = s1_par_reg ? (s1_syn_reg > SYN_MAX) : !syn_zero;
    fix_en   = sec_next && s1_mode_reg && !syn_zero;
  end

  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_syn_reg   <= '0;
      s1_par_reg   <= 1'b0;
      s1_data_reg  <= '0;
      s1_mode_reg  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_syn_reg  <= syn_next;
        s1_par_reg  <= par_next;
        s1_data_reg <= raw_next;
        s1_mode_reg <= correct_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sec_reg   <= 1'b0;
      out_ded_reg   <= 1'b0;
      out_syn_reg   <= '0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_data_reg <= corr_next;
        out_sec_reg  <= sec_next;
        out_ded_reg  <= ded_next;
        out_syn_reg  <= s1_syn_reg;
      end
    end
  end

  // Clear wins over a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      sec_cnt_reg <= '0;
      ded_cnt_reg <= '0;
    end else if (out_hs) begin
      if (out_sec_reg && (sec_cnt_reg != CNT_MAX)) sec_cnt_reg <= sec_cnt_reg + 1'b1;
      if (out_ded_reg && (ded_cnt_reg != CNT_MAX)) ded_cnt_reg <= ded_cnt_reg + 1'b1;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sec   = out_sec_reg;
  assign out_ded   = out_ded_reg;
  assign out_syn   = out_syn_reg;
  assign sec_cnt   = sec_cnt_reg;
  assign ded_cnt   = ded_cnt_reg;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Randomized and directed bench for secded_decoder_pipe (DATA_W=16, CNT_W=2)
// against a behavioural decode model and an in-flight word scoreboard.
module tb_secded_decoder_pipe;

  localparam int DATA_W  = 16;
  localparam int P       = 5;
  localparam int CW_W    = 22;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              sec;
    logic              ded;
    logic [P-1:0]      syn;
    int                acc_edge;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              correct_en;
  logic              cnt_clr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sec;
  logic              out_ded;
  logic [P-1:0]      out_syn;
  logic [CNT_W-1:0]  sec_cnt;
  logic [CNT_W-1:0]  ded_cnt;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   acc_total = 0;
  int   del_total = 0;
  int   m_sec_cnt = 0;
  int   m_ded_cnt = 0;
  exp_t q[$];
  exp_t front;
  exp_t nw;
  exp_t r;
  bit   m_ir;
  bit   m_ov;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  secded_decoder_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cw(in_cw), .correct_en(correct_en), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .out_syn(out_syn),
    .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [P-1:0] syndrome(input logic [CW_W-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i < CW_W; i++) if (cw[i]) s = s ^ P'(i);
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = cw[i];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    logic [P-1:0] s;
    int k;
    cw = '0;
    k = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    s = syndrome(cw);
    for (int b = 0; b < P; b++) cw[1 << b] = s[b];
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic exp_t ref_decode(input logic [CW_W-1:0] cw, input logic mode);
    exp_t e;
    logic [CW_W-1:0] c;
    logic p;
    int sv;
    e.syn = syndrome(cw);
    p = ^cw;
    sv = int'(e.syn);
    e.sec = p && (sv <= CW_W - 1);
    e.ded = (p && (sv >= CW_W)) || (!p && (sv != 0));
    c = cw;
    if (e.sec && mode && (sv != 0)) c[sv] = ~c[sv];
    e.data = extract(c);
    e.acc_edge = 0;
    return e;
  endfunction

  function automatic logic [CW_W-1:0] rand_cw();
    logic [CW_W-1:0] cw;
    int kind;
    int a;
    int b;
    cw = encode(DATA_W'($urandom));
    kind = $urandom_range(9, 0);
    a = $urandom_range(CW_W - 1, 0);
    b = (a + 1 + $urandom_range(CW_W - 2, 0)) % CW_W;
    if (kind >= 3 && kind < 6) cw[a] = ~cw[a];
    else if (kind >= 6 && kind < 8) begin
      cw[a] = ~cw[a];
      cw[b] = ~cw[b];
    end else if (kind == 8) cw = cw ^ CW_W'($urandom);
    else if (kind == 9) cw = CW_W'($urandom);
    return cw;
  endfunction

  // Compare process: outputs vs model every cycle, then advance the model
  // by whatever the coming clock edge will do.
  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      m_ir = (q.size() < 2) || out_ready;
      m_ov = (q.size() > 0) && (cyc > q[0].acc_edge);
      check("in_ready", 64'(in_ready), 64'(m_ir));
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        check("out_data", 64'(out_data), 64'(q[0].data));
        check("out_sec", 64'(out_sec), 64'(q[0].sec));
        check("out_ded", 64'(out_ded), 64'(q[0].ded));
        check("out_syn", 64'(out_syn), 64'(q[0].syn));
      end
      check("sec_cnt", 64'(sec_cnt), 64'(m_sec_cnt));
      check("ded_cnt", 64'(ded_cnt), 64'(m_ded_cnt));
      if (!rst_n) begin
        q.delete();
        m_sec_cnt = 0;
        m_ded_cnt = 0;
      end else begin
        if (m_ov && out_ready) begin
          front = q.pop_front();
          del_total++;
          if (front.sec && m_sec_cnt < CNT_MAX) m_sec_cnt++;
          if (front.ded && m_ded_cnt < CNT_MAX) m_ded_cnt++;
        end
        if (cnt_clr) begin
          m_sec_cnt = 0;
          m_ded_cnt = 0;
        end
        if (in_valid && m_ir) begin
          nw = ref_decode(in_cw, correct_en);
          nw.acc_edge = cyc + 1;
          q.push_back(nw);
          acc_total++;
        end
      end
    end
  end

  task automatic send(input logic [CW_W-1:0] cw, input logic mode);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_cw = cw;
    correct_en = mode;
    #2;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      #2;
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles, required 1", waited);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  logic [CW_W-1:0] base;
  int acc0;
  int del0;
  int waited;

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, required the bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_cw = '0;
    correct_en = 1'b1;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    base = 22'h28B45F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_sec", 64'(out_sec), 64'd0);
    check("rst out_ded", 64'(out_ded), 64'd0);
    check("rst out_syn", 64'(out_syn), 64'd0);
    check("rst sec_cnt", 64'(sec_cnt), 64'd0);
    check("rst ded_cnt", 64'(ded_cnt), 64'd0);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("in_ready after reset", 64'(in_ready), 64'd1);

    // Hand-computed values pinning the model.
    check("model encode A5A5", 64'(encode(16'hA5A5)), 64'h28B45F);
    r = ref_decode(base ^ 22'h80, 1'b1);
    check("model pos7 data", 64'(r.data), 64'hA5A5);
    check("model pos7 syn/sec/ded", 64'({r.syn, r.sec, r.ded}), 64'({5'd7, 1'b1, 1'b0}));
    r = ref_decode(base ^ 22'h80, 1'b0);
    check("model pos7 detect data", 64'(r.data), 64'hA5AD);
    r = ref_decode(base ^ 22'h28, 1'b1);
    check("model pos3+5 data", 64'(r.data), 64'hA5A6);
    check("model pos3+5 syn/sec/ded", 64'({r.syn, r.sec, r.ded}), 64'({5'd6, 1'b0, 1'b1}));
    r = ref_decode(base ^ 22'h1, 1'b1);
    check("model bit0 syn/sec/ded", 64'({r.syn, r.sec, r.ded}), 64'({5'd0, 1'b1, 1'b0}));
    check("model bit0 data", 64'(r.data), 64'hA5A5);

    // Clean word: latency of two cycles, literal outputs.
    send(base, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("latency out_valid early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("latency out_valid", 64'(out_valid), 64'd1);
    check("clean out_data", 64'(out_data), 64'hA5A5);
    check("clean flags", 64'({out_sec, out_ded, out_syn}), 64'd0);

    send(base ^ 22'h80, 1'b1);
    send(base ^ 22'h80, 1'b0);
    send(base ^ 22'h28, 1'b1);
    send(base ^ 22'h1, 1'b1);
    idle(6);
    check("directed sec_cnt", 64'(sec_cnt), 64'd3);
    check("directed ded_cnt", 64'(ded_cnt), 64'd1);

    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #2;
    check("idle clr sec_cnt", 64'(sec_cnt), 64'd0);
    check("idle clr ded_cnt", 64'(ded_cnt), 64'd0);

    for (int k = 1; k <= 5; k++) send(base ^ (22'h1 << k), 1'b1);
    idle(6);
    check("saturated sec_cnt", 64'(sec_cnt), 64'd3);

    // Clear coincident with a single-error output handshake.
    send(base ^ 22'h200, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("clr wait out_valid", 64'(out_valid), 64'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #2;
    check("clr priority sec_cnt", 64'(sec_cnt), 64'd0);

    // Backpressure: four words offered while out_ready is low for five cycles.
    acc0 = acc_total;
    del0 = del_total;
    fork
      begin
        send(encode(16'h1111), 1'b1);
        send(encode(16'h2222) ^ 22'h400, 1'b1);
        send(encode(16'h3333) ^ 22'h6, 1'b0);
        send(encode(16'h4444), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        check("stall in_ready", 64'(in_ready), 64'd0);
        check("stall accepts in 2..3", 64'((acc_total - acc0 >= 2) && (acc_total - acc0 <= 3)), 64'd1);
        check("stall no delivery", 64'(del_total - del0), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("stall accepted", 64'(acc_total - acc0), 64'd4);
    check("stall delivered", 64'(del_total - del0), 64'd4);

    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      in_valid = ($urandom_range(9, 0) < 7);
      in_cw = rand_cw();
      correct_en = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(9, 0) < 7);
      cnt_clr = ($urandom_range(31, 0) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    idle(6);

    // Reset with two single-error words in flight.
    send(base ^ 22'h80, 1'b1);
    send(base ^ 22'h80, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst sec_cnt", 64'(sec_cnt), 64'd0);
    check("midrst ded_cnt", 64'(ded_cnt), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    idle(8);
    check("midrst no stale word", 64'(out_valid), 64'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
